// File: rtl/frq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frq_pkg
// Description : Shared types and constants for the gated frequency meter.
//               - frq_state_e : measurement FSM states
//               - WARM_CYCLES : settle time after reset before measuring
//               - clog2()     : width helper for the gate counter
// Revision    : 1.0 - initial release
// ============================================================================
package frq_pkg;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } frq_state_e;

  // Cycles spent in WARM after reset; long enough for the synchronizer to
  // fill so a reset-cleared flop cannot fake a rising edge.
  localparam int WARM_CYCLES = 3;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : frq_sync_edge
// Description : Brings an asynchronous input into the clk domain through two
//               synchronizer flops plus one delay flop, and flags its rising
//               edges for one clk cycle.
// Ports       : clk     - system clock
//               reset_n - synchronous active-low reset
//               d       - asynchronous input
//               rise    - one-cycle pulse per synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module frq_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s1 may be metastable, so the edge is taken between the two settled stages.
  assign rise = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/frq_meter.sv
`default_nettype none
// ============================================================================
// Module      : frq_meter
// Description : Gated frequency meter. Counts rising edges of sig_in over a
//               window of GATE_CYCLES clk cycles and publishes the count with
//               a one-cycle valid strobe; runs back-to-back while en is high.
// Ports       : clk       - system clock
//               reset_n   - synchronous active-low reset
//               sig_in    - measured signal (asynchronous to clk)
//               en        - run measurements while high
//               count_out - edge count of the last completed window
//               valid     - one-cycle pulse when count_out updates
//               overflow  - count of that window saturated
//               busy      - high in WARM, GATE and LATCH
// Revision    : 1.0 - initial release
// ============================================================================
module frq_meter
  import frq_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int                GATE_W    = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [1:0]        WARM_LAST = 2'(WARM_CYCLES - 1);

  frq_state_e        state_q,    state_d;
  logic [1:0]        warm_q,     warm_d;
  logic [GATE_W-1:0] gate_q,     gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q,      sat_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              ovf_q,      ovf_d;
  logic              valid_q,    valid_d;

  logic              rise;
  logic [CNT_W-1:0]  cnt_inc;
  logic              sat_inc;

  frq_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sig_in),
    .rise    (rise)
  );

  // Edge counter after accumulating this cycle's edge, saturating at max.
  always_comb begin
    cnt_inc = edge_cnt_q;
    sat_inc = sat_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_WARM;
      warm_q     <= 2'd0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_WARM: begin
        warm_d = warm_q + 2'd1;
        if (warm_q == WARM_LAST) begin
          warm_d  = 2'd0;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (en) begin
          state_d    = ST_GATE;
          gate_d     = GATE_LOAD;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end

      ST_GATE: begin
        edge_cnt_d = cnt_inc;
        sat_d      = sat_inc;
        gate_d     = gate_q - GATE_W'(1);
        if (gate_q == '0) begin
          // Output registers are loaded on the way into LATCH (including the
          // final window cycle's edge) so they and valid change together
          // during the LATCH cycle.
          state_d = ST_LATCH;
          count_d = cnt_inc;
          ovf_d   = sat_inc;
          valid_d = 1'b1;
        end
      end

      ST_LATCH: begin
        // Dead cycle: any edge seen here is dropped by the reload.
        if (en) begin
          state_d    = ST_GATE;
          gate_d     = GATE_LOAD;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_WARM;
    endcase
  end

  assign count_out = count_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frq_meter
// Description : Self-checking bench for frq_meter. Two instances share one
//               stimulus stream: a 16-cycle window with a 16-bit count, and a
//               40-cycle window with a 3-bit count that saturates. A
//               behavioural model predicts each window's result into a
//               scoreboard queue; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frq_meter;

  localparam int P_WARM  = 0;
  localparam int P_IDLE  = 1;
  localparam int P_GATE  = 2;
  localparam int P_LATCH = 3;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sig_in;
  logic        en;
  logic [15:0] cnt0;
  logic        valid0, ovf0, busy0;
  logic [2:0]  cnt1;
  logic        valid1, ovf1, busy1;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit started = 0;

  // Reference model state, one slot per instance.
  int gwin[2] = '{16, 40};
  int maxc[2] = '{65535, 7};
  int m_ph[2];
  int m_left[2];
  int m_acc[2];
  bit m_sat[2];
  int m_cout[2];
  bit m_ovf[2];
  bit smp[$] = '{1'b0, 1'b0, 1'b0};  // smp[0] = sig_in as seen at previous edge
  exp_t q0[$];
  exp_t q1[$];

  // Stimulus generator controls (gen_hi = 0 holds the current level).
  int gen_hi = 0;
  int gen_lo = 0;
  int gcnt   = 0;

  frq_meter #(.GATE_CYCLES(16), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .en(en),
    .count_out(cnt0), .valid(valid0), .overflow(ovf0), .busy(busy0)
  );

  frq_meter #(.GATE_CYCLES(40), .CNT_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .en(en),
    .count_out(cnt1), .valid(valid1), .overflow(ovf1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, i, cyc, act, exp);
    end
  endtask

  // Model: an edge of sig_in counts if the sample taken two edges ago was high
  // and the one three edges ago was low, and only while a window is open.
  always @(posedge clk) begin
    bit r;
    exp_t e;
    cyc++;
    started = 1;
    r = smp[1] && !smp[2];
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_ph[i]   = P_WARM;
        m_left[i] = 3;
        m_cout[i] = 0;
        m_ovf[i]  = 0;
      end else begin
        case (m_ph[i])
          P_WARM: begin
            m_left[i]--;
            if (m_left[i] == 0) m_ph[i] = P_IDLE;
          end
          P_IDLE, P_LATCH: begin
            if (en) begin
              m_ph[i]   = P_GATE;
              m_left[i] = gwin[i];
              m_acc[i]  = 0;
              m_sat[i]  = 0;
            end else begin
              m_ph[i] = P_IDLE;
            end
          end
          default: begin
            if (r) begin
              if (m_acc[i] == maxc[i]) m_sat[i] = 1;
              else m_acc[i]++;
            end
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_ph[i]   = P_LATCH;
              m_cout[i] = m_acc[i];
              m_ovf[i]  = m_sat[i];
              e.cyc = cyc;
              e.cnt = m_acc[i];
              e.ovf = m_sat[i];
              if (i == 0) q0.push_back(e);
              else q1.push_back(e);
            end
          end
        endcase
      end
    end
    smp.push_front(reset_n ? sig_in : 1'b0);
    void'(smp.pop_back());
  end

  task automatic check_dut(input int i, input logic vld, input int cnt,
                           input logic ov, input logic bsy);
    exp_t e;
    bit have;
    have = 0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        have = 1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        have = 1;
      end
    end
    chk("valid", i, int'(vld), int'(have));
    if (have && vld) begin
      chk("window_count", i, cnt, e.cnt);
      chk("window_overflow", i, int'(ov), int'(e.ovf));
    end else begin
      chk("count_held", i, cnt, m_cout[i]);
      chk("overflow_held", i, int'(ov), int'(m_ovf[i]));
    end
    chk("busy", i, int'(bsy), int'(m_ph[i] != P_IDLE));
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_dut(0, valid0, int'(cnt0), ovf0, busy0);
      check_dut(1, valid1, int'(cnt1), ovf1, busy1);
    end
  end

  initial begin
    sig_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (gen_hi > 0) begin
        gcnt++;
        if (sig_in && gcnt >= gen_hi) begin
          sig_in = 1'b0;
          gcnt   = 0;
        end else if (!sig_in && gcnt >= gen_lo) begin
          sig_in = 1'b1;
          gcnt   = 0;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_period(input int hi, input int lo);
    gen_lo = lo;
    gen_hi = hi;
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    en      = 1'b1;
    cycles(4);
    reset_n = 1'b1;

    // Constant-high input through warm-up: first window must read 0.
    cycles(30);

    set_period(2, 2);
    cycles(17 * 4);
    set_period(4, 4);
    cycles(17 * 3);
    set_period(1, 1);
    cycles(17 * 3);

    repeat (6) begin
      set_period($urandom_range(2, 6), $urandom_range(2, 6));
      cycles($urandom_range(10, 40));
    end

    // Period 4 long enough for the 3-bit instance to saturate.
    set_period(2, 2);
    cycles(90);

    // Single-cycle en pulse from IDLE.
    en = 1'b0;
    k = 0;
    while (m_ph[0] != P_IDLE && k < 100) begin
      cycles(1);
      k++;
    end
    chk("wait_idle", 0, int'(m_ph[0] == P_IDLE), 1);
    cycles(5);
    en = 1'b1;
    cycles(1);
    en = 1'b0;
    cycles(30);

    // One-cycle reset halfway through a window.
    set_period(3, 3);
    en = 1'b1;
    k = 0;
    while (!(m_ph[0] == P_GATE && m_left[0] == 8) && k < 100) begin
      cycles(1);
      k++;
    end
    chk("wait_gate", 0, int'(m_ph[0] == P_GATE && m_left[0] == 8), 1);
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(60);

    en = 1'b0;
    cycles(50);
    chk("scoreboard_empty", 0, q0.size(), 0);
    chk("scoreboard_empty", 1, q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
